// File: rtl/bombe_pkg.sv
// Shared types and constants for the bombe search scheduler.
// State encoding, error value, ASCII crib bounds, default position count.
package bombe_pkg;

  typedef enum logic [2:0] {
    LOAD0  = 3'd0,
    LOAD1  = 3'd1,
    LOAD2  = 3'd2,
    ARMED  = 3'd3,
    SEARCH = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [7:0] ERR_VAL = 8'hFF;
  localparam logic [7:0] ORD_A   = 8'h41;
  localparam logic [7:0] ORD_Z   = 8'h5A;
  localparam int NUM_POS_DEF     = 26;

endpackage

// File: rtl/bombe_pos_counter.sv
// Rotor position counter: sync clear, enable, terminal flag at NUM_POS-1.
// Ports: clk, reset_n, clr, en -> pos, last. Never counts past NUM_POS-1.
module bombe_pos_counter #(
  parameter int NUM_POS = 26,
  parameter int POS_W   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [POS_W-1:0] pos,
  output logic             last
);

  localparam logic [POS_W-1:0] LAST_POS =
    POS_W'(NUM_POS - 1);

  assign last = (pos == LAST_POS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (en && !last) begin
      pos <= pos + POS_W'(1);
    end
  end

endmodule

// File: rtl/bombe_search_scheduler.sv
// Bombe crib loader and rotor search sequencer (macro BOMBE_CHAR_FILTER_EN).
// Ports: char_* handshake, go/clear/step_tick/match_in -> load_sel, dp_reset, rotor_pos, busy/done/found/result, char_err.
module bombe_search_scheduler
  import bombe_pkg::*;
#(
  parameter int NUM_POS = NUM_POS_DEF,
  parameter int POS_W   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic             go,
  input  logic             clear,
  input  logic             step_tick,
  input  logic             match_in,
  output logic [2:0]       load_sel,
  output logic             dp_reset,
  output logic [POS_W-1:0] rotor_pos,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [7:0]       result,
  output logic             char_err
);

  state_t     state_q, state_d;
  logic       cnt_clr, cnt_en, cnt_last;
  logic       hit, miss, rerun;
  logic       found_q, dp_reset_q;
  logic [7:0] result_q;
  logic       char_ok;

`ifdef BOMBE_CHAR_FILTER_EN
  // Non-letters are consumed but never reach the crib registers.
  assign char_ok  = (char_in >= ORD_A) && (char_in <= ORD_Z);
  assign char_err = char_ready & char_valid
                  & ~char_ok & ~clear;
`else
  assign char_ok  = 1'b1;
  assign char_err = 1'b0;
`endif

  bombe_pos_counter #(
    .NUM_POS (NUM_POS),
    .POS_W   (POS_W)
  ) u_pos (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .pos     (rotor_pos),
    .last    (cnt_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    char_ready = 1'b0;
    load_sel   = 3'b000;
    busy       = 1'b0;
    done       = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
    rerun      = 1'b0;
    unique case (state_q)
      LOAD0: begin
        char_ready = 1'b1;
        if (char_valid && char_ok) begin
          load_sel = 3'b001;
          state_d  = LOAD1;
        end
      end
      LOAD1: begin
        char_ready = 1'b1;
        if (char_valid && char_ok) begin
          load_sel = 3'b010;
          state_d  = LOAD2;
        end
      end
      LOAD2: begin
        char_ready = 1'b1;
        if (char_valid && char_ok) begin
          load_sel = 3'b100;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (go) begin
          cnt_clr = 1'b1;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        busy = 1'b1;
        if (step_tick) begin
          if (match_in) begin
            hit     = 1'b1;
            state_d = DONE;
          end else if (cnt_last) begin
            miss    = 1'b1;
            state_d = DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (go) begin
          cnt_clr = 1'b1;
          rerun   = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = LOAD0;
    endcase
    // Clear overrides every other request in the same cycle.
    if (clear) begin
      state_d  = LOAD0;
      load_sel = 3'b000;
      cnt_clr  = 1'b1;
      cnt_en   = 1'b0;
      hit      = 1'b0;
      miss     = 1'b0;
      rerun    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found_q    <= 1'b0;
      result_q   <= 8'h00;
      dp_reset_q <= 1'b0;
    end else begin
      dp_reset_q <= clear;
      if (clear || rerun) begin
        found_q  <= 1'b0;
        result_q <= 8'h00;
      end else if (hit) begin
        found_q  <= 1'b1;
        result_q <= 8'(rotor_pos);
      end else if (miss) begin
        found_q  <= 1'b0;
        result_q <= ERR_VAL;
      end
    end
  end

  assign found    = found_q;
  assign result   = result_q;
  assign dp_reset = dp_reset_q;

endmodule

// File: tb/tb_bombe_search_scheduler.sv
// Directed plus randomized bench for bombe_search_scheduler.
// Reference: match position m gives result m after m+1 ticks, none gives FF after 26.
module tb_bombe_search_scheduler;

  localparam int NP = 26;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    char_in;
  logic          char_valid;
  logic          char_ready;
  logic          go;
  logic          clear;
  logic          step_tick;
  logic          match_in;
  logic [2:0]    load_sel;
  logic          dp_reset;
  logic [PW-1:0] rotor_pos;
  logic          busy;
  logic          done;
  logic          found;
  logic [7:0]    result;
  logic          char_err;

  int vectors    = 0;
  int miscompares = 0;
  int match_tgt  = NP;

  bombe_search_scheduler #(
    .NUM_POS (NP),
    .POS_W   (PW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .go         (go),
    .clear      (clear),
    .step_tick  (step_tick),
    .match_in   (match_in),
    .load_sel   (load_sel),
    .dp_reset   (dp_reset),
    .rotor_pos  (rotor_pos),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .result     (result),
    .char_err   (char_err)
  );

  always #5 clk = ~clk;

  // Emulated datapath: equality holds only at the target position.
  assign match_in = (match_tgt < NP) &&
                    (int'(rotor_pos) == match_tgt);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_char(input logic [7:0] c,
                           input logic [2:0] sel);
    char_in    = c;
    char_valid = 1'b1;
    #1;
    chk("char_ready", 32'(char_ready), 32'd1);
    chk("load_sel", 32'(load_sel), 32'(sel));
    chk("char_err", 32'(char_err), 32'd0);
    cyc();
    char_valid = 1'b0;
  endtask

  task automatic load_crib(input logic [7:0] a,
                           input logic [7:0] b,
                           input logic [7:0] c);
    load_char(a, 3'b001);
    load_char(b, 3'b010);
    load_char(c, 3'b100);
    #1;
    chk("armed_ready", 32'(char_ready), 32'd0);
  endtask

  // Starts from ARMED or DONE; m == NP means no position matches.
  task automatic run_search(input int m, input int spacing);
    int ticks;
    int phase;
    bit got;
    int exp_ticks;
    int exp_res;
    int exp_pos;
    ticks = 0;
    phase = 0;
    got = 0;
    match_tgt = m;
    exp_ticks = (m < NP) ? m + 1 : NP;
    exp_res   = (m < NP) ? m : 255;
    exp_pos   = (m < NP) ? m : NP - 1;
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk("go_busy", 32'(busy), 32'd1);
    chk("go_done_clr", 32'(done), 32'd0);
    chk("go_pos0", 32'(rotor_pos), 32'd0);
    for (int i = 0; i < 400; i++) begin
      step_tick = (phase == 0);
      phase = (phase + 1) % spacing;
      #1;
      if (step_tick && busy) ticks++;
      cyc();
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("search_timeout", 32'(got), 32'd1);
    chk("done_after_tick", 32'(step_tick), 32'd1);
    step_tick = 1'b0;
    chk("ticks", 32'(ticks), 32'(exp_ticks));
    chk("found", 32'(found), 32'(m < NP));
    chk("result", 32'(result), 32'(exp_res));
    chk("final_pos", 32'(rotor_pos), 32'(exp_pos));
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    go         = 1'b0;
    clear      = 1'b0;
    step_tick  = 1'b0;
    cyc();
    cyc();
    chk("rst_ready", 32'(char_ready), 32'd1);
    chk("rst_sel", 32'(load_sel), 32'd0);
    chk("rst_dpr", 32'(dp_reset), 32'd0);
    chk("rst_pos", 32'(rotor_pos), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_err", 32'(char_err), 32'd0);
    reset_n = 1'b1;
    cyc();

    // 'D','F','H', match at 3, tick every 4 cycles.
    load_crib(8'h44, 8'h46, 8'h48);
    run_search(3, 4);

    // 'Z','Z','Z', no match, full sweep.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_dpr", 32'(dp_reset), 32'd1);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_result", 32'(result), 32'd0);
    cyc();
    chk("dpr_pulse", 32'(dp_reset), 32'd0);
    load_crib(8'h5A, 8'h5A, 8'h5A);
    run_search(NP, 1);

    // Match on the very first tick, then rerun from DONE.
    run_search(0, 2);
    run_search(0, 1);

    // Randomized reruns against the reference rule.
    for (int r = 0; r < 6; r++) begin
      run_search(int'($urandom_range(0, NP)),
                 int'($urandom_range(1, 3)));
    end

    // clear + go + tick together at position 10.
    match_tgt = NP;
    go = 1'b1;
    cyc();
    go = 1'b0;
    step_tick = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (int'(rotor_pos) == 10) break;
      cyc();
    end
    chk("reach_10", 32'(rotor_pos), 32'd10);
    clear = 1'b1;
    go    = 1'b1;
    cyc();
    clear = 1'b0;
    go    = 1'b0;
    step_tick = 1'b0;
    chk("cg_busy", 32'(busy), 32'd0);
    chk("cg_done", 32'(done), 32'd0);
    chk("cg_pos", 32'(rotor_pos), 32'd0);
    chk("cg_dpr", 32'(dp_reset), 32'd1);
    chk("cg_ready", 32'(char_ready), 32'd1);

    // Async reset mid-search.
    load_crib(8'h41, 8'h42, 8'h43);
    go = 1'b1;
    cyc();
    go = 1'b0;
    step_tick = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("pre_rst_pos", 32'(rotor_pos), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pos", 32'(rotor_pos), 32'd0);
    chk("arst_ready", 32'(char_ready), 32'd1);
    chk("arst_done", 32'(done), 32'd0);
    step_tick = 1'b0;
    cyc();
    reset_n = 1'b1;
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk("go_in_load_busy", 32'(busy), 32'd0);
    chk("go_in_load_ready", 32'(char_ready), 32'd1);

`ifdef BOMBE_CHAR_FILTER_EN
    char_in    = 8'h33;
    char_valid = 1'b1;
    #1;
    chk("flt_err", 32'(char_err), 32'd1);
    chk("flt_sel", 32'(load_sel), 32'd0);
    cyc();
    char_valid = 1'b0;
    #1;
    chk("flt_err_end", 32'(char_err), 32'd0);
    load_char(8'h41, 3'b001);
`else
    char_in    = 8'h33;
    char_valid = 1'b1;
    #1;
    chk("nf_sel", 32'(load_sel), 32'd1);
    chk("nf_err", 32'(char_err), 32'd0);
    cyc();
    char_valid = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
